digital_time_counter: RTL
=========================

DIGITAL_TIME_COUNTER -- requirements
Module: digital_time_counter

Interface
REQ-001 SHALL provide parameter RST_HOUR, default 0, binary hour (0-23) loaded on reset.
REQ-002 SHALL provide parameter RST_MIN, default 0, binary minute (0-59) loaded on reset.
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port clk_1hz  input  1  1 Hz square wave from the upstream divider, synchronous to clk; each rising level change is one second.
REQ-006 SHALL provide port mode_btn  input  1  debounced mode button, active-high, may be held any number of cycles.
REQ-007 SHALL provide port inc_btn  input  1  debounced increment button, active-high, may be held any number of cycles.
REQ-008 SHALL provide ports hr_t, hr_o, min_t, min_o, sec_t, sec_o  output  4 each  BCD tens/ones digits of hours, minutes, seconds, all registered.
REQ-009 SHALL provide port set_mode  output  2  registered FSM state: 00 RUN, 01 SET_HR, 10 SET_MIN.
REQ-010 SHALL provide port sec_pulse  output  1  registered one-clk pulse per counted second.

Function
REQ-011 Edge detect: register clk_1hz into clk_1hz_q; tick = clk_1hz AND NOT clk_1hz_q, evaluated at every clk edge.
REQ-012 Tick latency: in RUN, digits update at the same clk edge that first samples clk_1hz high; sec_pulse high for exactly that following cycle.
REQ-013 Seconds: 0-59 BCD; ones 9->0 increments tens; 59->00 generates minute carry in the same edge.
REQ-014 Minutes: 0-59 BCD, same rule; 59->00 with carry generates hour carry in the same edge.
REQ-015 Hours: 00-23 BCD; 23->00 on carry; 19->20 and 09->10 via ones wrap; 23:59:59 + tick -> 00:00:00 in one edge.
REQ-016 BCD digits SHALL never hold values >9, sec_t/min_t never >5, hr_t never >2.
REQ-017 Button edge detect: mode_btn and inc_btn each registered; an action fires only on the 0->1 transition; holding a button fires once.
REQ-018 FSM: RUN --mode--> SET_HR --mode--> SET_MIN --mode--> RUN; no other transitions except reset.
REQ-019 Entering SET_HR: seconds cleared to 00 at the transition edge.
REQ-020 SET_HR: inc edge increments hours mod 24 (23->00); minutes and seconds unchanged; no carry.
REQ-021 SET_MIN: inc edge increments minutes mod 60 (59->00); hours unchanged; no carry to hours.
REQ-022 In SET_HR/SET_MIN, ticks SHALL be ignored: seconds held at 00, sec_pulse held 0; clk_1hz_q still tracks clk_1hz.
REQ-023 Returning SET_MIN->RUN: counting resumes from 00 seconds on the next tick; a tick coinciding with the transition edge is ignored.
REQ-024 Simultaneous mode and inc edges: mode action taken, inc ignored.
REQ-025 Tick and inc edge same cycle in RUN: inc ignored, tick counted.

Reset
REQ-026 While rst_n low at a clk edge: hours = RST_HOUR, minutes = RST_MIN, seconds = 00, set_mode = 00, sec_pulse = 0, clk_1hz_q = 0, button registers = 0.
REQ-027 Reset SHALL override all activity, including mid-set and mid-carry; no tick or button action is taken in the reset cycle.
REQ-028 After release, a clk_1hz already high SHALL count one tick at the first edge (clk_1hz_q reset to 0); a held button SHALL fire once.
REQ-029 Asynchronous reset behaviour SHALL NOT exist: rst_n is sampled only on clk.

Verification
REQ-030 Reset with RST_HOUR=0, RST_MIN=0, then 1 tick -> 00:00:01, sec_pulse high one cycle after the edge that sees clk_1hz high.
REQ-031 Preload 23:59:58 (via set mode), 2 ticks -> 23:59:59 then 00:00:00 in a single edge.
REQ-032 In RUN, mode edge -> set_mode=01, seconds=00; inc held 50 cycles -> hours +1 only; 25 inc pulses from 00 -> hours 01.
REQ-033 SET_MIN at 59, inc pulse -> 00, hours unchanged; ticks during set -> seconds stay 00, no sec_pulse.
REQ-034 mode and inc rising in the same cycle in SET_HR -> set_mode=10, hours unchanged.
REQ-035 rst_n low during SET_MIN at 12:34 -> next cycle RST_HOUR:RST_MIN:00, set_mode=00.

Source files
------------

// File: rtl/digital_time_counter.sv
// 24-hour BCD time-of-day counter with RUN / set-hours / set-minutes modes.
// Seconds advance on rising edges of clk_1hz; the buttons act only on their rising edges.
module digital_time_counter #(
  parameter int RST_HOUR = 0,
  parameter int RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] set_mode,
  output logic       sec_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  localparam logic [3:0] RST_HR_T  = 4'(RST_HOUR / 10);
  localparam logic [3:0] RST_HR_O  = 4'(RST_HOUR % 10);
  localparam logic [3:0] RST_MIN_T = 4'(RST_MIN / 10);
  localparam logic [3:0] RST_MIN_O = 4'(RST_MIN % 10);

  mode_t      state, next_state;
  logic       clk_1hz_q, mode_q, inc_q;
  logic       tick, mode_edge, inc_edge;
  logic       min_step, hr_step, min_wrap;
  logic [3:0] next_hr_t, next_hr_o, next_min_t, next_min_o, next_sec_t, next_sec_o;
  logic       next_sec_pulse;

  assign tick      = clk_1hz & ~clk_1hz_q;
  assign mode_edge = mode_btn & ~mode_q;
  assign inc_edge  = inc_btn & ~inc_q;
  assign set_mode  = state;

  always_comb begin
    next_state     = state;
    next_hr_t      = hr_t;
    next_hr_o      = hr_o;
    next_min_t     = min_t;
    next_min_o     = min_o;
    next_sec_t     = sec_t;
    next_sec_o     = sec_o;
    next_sec_pulse = 1'b0;
    min_step       = 1'b0;
    hr_step        = 1'b0;
    min_wrap       = 1'b0;

    // A mode edge always wins: it suppresses any tick or inc seen in the same cycle.
    case (state)
      RUN: begin
        if (mode_edge) begin
          next_state = SET_HR;
          next_sec_t = 4'd0;
          next_sec_o = 4'd0;
        end else if (tick) begin
          next_sec_pulse = 1'b1;
          if (sec_o == 4'd9) begin
            next_sec_o = 4'd0;
            if (sec_t == 4'd5) begin
              next_sec_t = 4'd0;
              min_step   = 1'b1;
            end else begin
              next_sec_t = sec_t + 4'd1;
            end
          end else begin
            next_sec_o = sec_o + 4'd1;
          end
        end
      end
      SET_HR: begin
        if (mode_edge) next_state = SET_MIN;
        else if (inc_edge) hr_step = 1'b1;
      end
      SET_MIN: begin
        if (mode_edge) next_state = RUN;
        else if (inc_edge) min_step = 1'b1;
      end
      default: next_state = RUN;
    endcase

    if (min_step) begin
      if (min_o == 4'd9) begin
        next_min_o = 4'd0;
        if (min_t == 4'd5) begin
          next_min_t = 4'd0;
          min_wrap   = 1'b1;
        end else begin
          next_min_t = min_t + 4'd1;
        end
      end else begin
        next_min_o = min_o + 4'd1;
      end
    end

    // Minute wrap only carries into hours while the clock is running.
    if (hr_step || (min_wrap && state == RUN)) begin
      if (hr_t == 4'd2 && hr_o == 4'd3) begin
        next_hr_t = 4'd0;
        next_hr_o = 4'd0;
      end else if (hr_o == 4'd9) begin
        next_hr_t = hr_t + 4'd1;
        next_hr_o = 4'd0;
      end else begin
        next_hr_o = hr_o + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      clk_1hz_q <= 1'b0;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      hr_t      <= RST_HR_T;
      hr_o      <= RST_HR_O;
      min_t     <= RST_MIN_T;
      min_o     <= RST_MIN_O;
      sec_t     <= 4'd0;
      sec_o     <= 4'd0;
      sec_pulse <= 1'b0;
    end else begin
      state     <= next_state;
      clk_1hz_q <= clk_1hz;
      mode_q    <= mode_btn;
      inc_q     <= inc_btn;
      hr_t      <= next_hr_t;
      hr_o      <= next_hr_o;
      min_t     <= next_min_t;
      min_o     <= next_min_o;
      sec_t     <= next_sec_t;
      sec_o     <= next_sec_o;
      sec_pulse <= next_sec_pulse;
    end
  end

endmodule
